// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic state_is_busy(input state_e s);
        return (s == ST_RUN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Gate-level single-bit full adder; the only arithmetic in the serial adder.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w1;
    logic w2;
    logic w3;

    xor g_x1 (w1, a, b);
    xor g_x2 (s, w1, cin);
    and g_a1 (w2, a, b);
    and g_a2 (w3, w1, cin);
    or  g_o1 (cout, w2, w3);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full-adder cell LSB first over WIDTH
// cycles and presents {cout,sum} with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_e           dbg_state
);

    // Handshake: start is sampled only while idle (busy=0); a/b/cin are captured
    // on that same edge. Requests while busy are dropped. done is a one-cycle
    // pulse and sum/cout stay valid from that pulse until the next result.

    state_e           state_q;
    state_e           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             cout_d;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] work_shift;

    fa_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign last_bit   = (cnt_q == CW'(WIDTH - 1));
    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign work_shift = WIDTH'({fa_s, work_q} >> 1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = state_is_busy(state_q);
        done      = (state_q == ST_DONE);
        dbg_state = state_q;
    end

    // Datapath next-state: operand shifting, carry, bit counter and result capture
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    work_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                work_d  = work_shift;
                cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d  = work_shift;
                    cout_d = fa_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit instance for timing/handshake scenarios
// and a 4-bit instance swept over every (a,b,cin) combination.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W8 = 8;
    localparam int W4 = 4;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;

    logic          start8;
    logic [W8-1:0] a8;
    logic [W8-1:0] b8;
    logic          cin8;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] sum8;
    logic          cout8;
    state_e        st8;

    logic          start4;
    logic [W4-1:0] a4;
    logic [W4-1:0] b4;
    logic          cin4;
    logic          busy4;
    logic          done4;
    logic [W4-1:0] sum4;
    logic          cout4;
    state_e        st4;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .dbg_state(st8)
    );

    serial_adder_ctrl #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .dbg_state(st4)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: request on an IDLE cycle, then scramble operands after the accepting edge
    task automatic start_op8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic cv);
        @(negedge clk);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        cin8   = cv;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8     = 8'($urandom_range(0, 255));
        b8     = 8'($urandom_range(0, 255));
        cin8   = 1'($urandom_range(0, 1));
    endtask

    // Counts cycles from the accepting edge to done; flags any result change before done
    task automatic wait_done8(output int lat, output bit moved);
        logic [W8-1:0] s0;
        logic          c0;
        s0    = sum8;
        c0    = cout8;
        lat   = 0;
        moved = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done8) break;
            if (sum8 !== s0 || cout8 !== c0) moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags8: busy=%b done=%b expected 0 0", busy8, done8);
        end
        checks++;
        if ({cout8, sum8} !== 9'h000) begin
            errors++;
            $display("FAIL reset_result8: got %h expected 000", {cout8, sum8});
        end
        checks++;
        if (st8 !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state8: got %0d expected %0d", st8, ST_IDLE);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || {cout4, sum4} !== 5'h00) begin
            errors++;
            $display("FAIL reset_dut4: busy=%b done=%b result=%h expected 0 0 00",
                     busy4, done4, {cout4, sum4});
        end
    endtask

    task automatic test_basic();
        logic [W8-1:0] ta [0:3];
        logic [W8-1:0] tb [0:3];
        logic          tc [0:3];
        logic [W8-1:0] av;
        logic [W8-1:0] bv;
        logic          cv;
        logic [W8:0]   exp;
        int            lat;
        bit            moved;
        ta = '{8'h00, 8'hFF, 8'hA5, 8'h7F};
        tb = '{8'h00, 8'h01, 8'h5A, 8'h01};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 20; i++) begin
            if (i < 4) begin
                av = ta[i];
                bv = tb[i];
                cv = tc[i];
            end else begin
                av = 8'($urandom_range(0, 255));
                bv = 8'($urandom_range(0, 255));
                cv = 1'($urandom_range(0, 1));
            end
            exp = 9'(av) + 9'(bv) + 9'(cv);
            start_op8(av, bv, cv);
            wait_done8(lat, moved);
            checks++;
            if (!done8 || lat != W8 + 1) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d cycles (done=%b) expected %0d", i, lat, done8, W8 + 1);
            end
            checks++;
            if ({cout8, sum8} !== exp) begin
                errors++;
                $display("FAIL basic_sum[%0d]: %h+%h+%b got %h expected %h", i, av, bv, cv, {cout8, sum8}, exp);
            end
            checks++;
            if (moved || busy8 !== 1'b1) begin
                errors++;
                $display("FAIL basic_run[%0d]: result_moved=%b busy_at_done=%b expected 0 1", i, moved, busy8);
            end
            @(negedge clk);
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== exp) begin
                errors++;
                $display("FAIL basic_after[%0d]: busy=%b done=%b result=%h expected 0 0 %h",
                         i, busy8, done8, {cout8, sum8}, exp);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int          ndone;
        int          dlat;
        logic [W8:0] res;
        ndone = 0;
        dlat  = 0;
        res   = '0;
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h12;
        b8     = 8'h34;
        cin8   = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (done8) begin
                ndone++;
                dlat = lat;
                res  = {cout8, sum8};
            end
            if (lat == 3) begin
                start8 = 1'b1;
                a8     = 8'hFF;
                b8     = 8'hFF;
                cin8   = 1'b1;
            end else begin
                start8 = 1'b0;
            end
        end
        checks++;
        if (ndone != 1 || dlat != W8 + 1) begin
            errors++;
            $display("FAIL ignore_pulses: got %0d pulses (last at %0d) expected 1 at %0d", ndone, dlat, W8 + 1);
        end
        checks++;
        if (res !== 9'h046) begin
            errors++;
            $display("FAIL ignore_sum: got %h expected 046", res);
        end
    endtask

    task automatic test_back_to_back();
        int            t [0:1];
        logic [W8-1:0] s [0:1];
        int            nd;
        bit            unstable;
        nd       = 0;
        unstable = 1'b0;
        t        = '{0, 0};
        s        = '{8'h00, 8'h00};
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h01;
        b8     = 8'h01;
        cin8   = 1'b0;
        @(posedge clk);
        #1;
        a8 = 8'h03;
        b8 = 8'h03;
        for (int lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (done8) begin
                t[nd] = lat;
                s[nd] = sum8;
                nd++;
                if (nd == 2) begin
                    start8 = 1'b0;
                    break;
                end
            end else if (nd == 1 && sum8 !== 8'h02) begin
                unstable = 1'b1;
            end
        end
        start8 = 1'b0;
        checks++;
        if (nd != 2 || t[0] != W8 + 1 || t[1] - t[0] != W8 + 2) begin
            errors++;
            $display("FAIL b2b_timing: pulses=%0d at %0d,%0d expected 2 at %0d,%0d",
                     nd, t[0], t[1], W8 + 1, 2 * W8 + 3);
        end
        checks++;
        if (s[0] !== 8'h02 || s[1] !== 8'h06) begin
            errors++;
            $display("FAIL b2b_sums: got %h,%h expected 02,06", s[0], s[1]);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL b2b_hold: sum changed between pulses, expected 02 held");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat;
        bit moved;
        int stray;
        start_op8(8'h12, 8'h34, 1'b0);
        wait_done8(lat, moved);
        checks++;
        if ({cout8, sum8} !== 9'h046) begin
            errors++;
            $display("FAIL abort_setup: got %h expected 046", {cout8, sum8});
        end
        start_op8(8'h55, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b1 || sum8 !== 8'h46) begin
            errors++;
            $display("FAIL abort_midrun: busy=%b sum=%h expected 1 46", busy8, sum8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || {cout8, sum8} !== 9'h000) begin
            errors++;
            $display("FAIL abort_async: busy=%b done=%b result=%h expected 0 0 000",
                     busy8, done8, {cout8, sum8});
        end
        @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", stray);
        end
        start_op8(8'h10, 8'h20, 1'b0);
        wait_done8(lat, moved);
        checks++;
        if (!done8 || lat != W8 + 1 || {cout8, sum8} !== 9'h030) begin
            errors++;
            $display("FAIL abort_rerun: done=%b lat=%0d result=%h expected 1 %0d 030",
                     done8, lat, {cout8, sum8}, W8 + 1);
        end
    endtask

    task automatic test_exhaustive4();
        int          ndone;
        int          lat;
        int          shown;
        logic [W4:0] exp;
        ndone = 0;
        shown = 0;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    start4 = 1'b1;
                    a4     = 4'(ai);
                    b4     = 4'(bi);
                    cin4   = 1'(ci);
                    @(posedge clk);
                    #1;
                    start4 = 1'b0;
                    a4     = 4'($urandom_range(0, 15));
                    b4     = 4'($urandom_range(0, 15));
                    lat    = 0;
                    while (lat < 20) begin
                        @(negedge clk);
                        lat++;
                        if (done4) break;
                    end
                    if (done4) ndone++;
                    exp = 5'(ai + bi + ci);
                    checks++;
                    if (!done4 || lat != W4 + 1 || {cout4, sum4} !== exp) begin
                        errors++;
                        if (shown < 10) begin
                            shown++;
                            $display("FAIL exh4 %0d+%0d+%0d: done=%b lat=%0d result=%h expected 1 %0d %h",
                                     ai, bi, ci, done4, lat, {cout4, sum4}, W4 + 1, exp);
                        end
                    end
                end
            end
        end
        checks++;
        if (ndone != 512) begin
            errors++;
            $display("FAIL exh4_count: got %0d done pulses expected 512", ndone);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        cin4   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
